// File: rtl/vga_text_avl_writer.sv
// Avalon-MM master that turns character-put, screen-clear and palette commands
// into byte-enabled transfers into the VGA text display's VRAM and palette.
module vga_text_avl_writer #(
  parameter int          COLS     = 80,
  parameter int          ROWS     = 30,
  parameter logic [11:0] PAL_BASE = 12'h800
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [6:0]  CMD_X,
  input  logic [4:0]  CMD_Y,
  input  logic [7:0]  CMD_CHAR,
  input  logic [7:0]  CMD_ATTR,
  input  logic [31:0] CMD_DATA,
  output logic        RSP_VALID,
  output logic        RSP_ERR,
  output logic [31:0] RSP_DATA,
  output logic [11:0] AVM_ADDR,
  output logic        AVM_CS,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST
);
  localparam logic [1:0]  OP_PUT   = 2'd0;
  localparam logic [1:0]  OP_CLEAR = 2'd1;
  localparam logic [1:0]  OP_PWR   = 2'd2;
  localparam logic [1:0]  OP_PRD   = 2'd3;
  localparam logic [6:0]  LP_COLS  = 7'(COLS);
  localparam logic [4:0]  LP_ROWS  = 5'(ROWS);
  localparam logic [10:0] LP_LAST  = 11'(COLS * ROWS / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CLR, S_DONE} state_t;

  state_t      r_state, w_nxt;
  logic        w_acc;
  logic [11:0] w_idx;
  logic        w_oor;
  logic [15:0] w_entry;
  logic [11:0] w_pal_addr;
  logic [11:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [10:0] r_cnt;
  logic        r_err;

  assign w_idx      = 12'(CMD_Y) * 12'(COLS) + 12'(CMD_X);
  assign w_oor      = (CMD_X >= LP_COLS) || (CMD_Y >= LP_ROWS);
  assign w_entry    = {CMD_CHAR, CMD_ATTR};
  assign w_pal_addr = PAL_BASE | {9'd0, CMD_DATA[2:0]};

  assign CMD_READY     = (r_state == S_IDLE);
  assign AVM_WRITE     = (r_state == S_WR) || (r_state == S_CLR);
  assign AVM_READ      = (r_state == S_RD);
  assign AVM_CS        = AVM_WRITE | AVM_READ;
  assign AVM_ADDR      = r_addr;
  assign AVM_BYTE_EN   = r_be;
  assign AVM_WRITEDATA = r_wdata;
  assign RSP_VALID     = (r_state == S_DONE);
  assign RSP_ERR       = RSP_VALID & r_err;
  assign RSP_DATA      = r_rdata;

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    w_acc = 1'b0;
    case (r_state)
      S_IDLE: if (CMD_VALID) begin
        w_acc = 1'b1;
        case (CMD_OP)
          OP_PUT:   w_nxt = w_oor ? S_DONE : S_WR;
          OP_CLEAR: w_nxt = S_CLR;
          OP_PWR:   w_nxt = S_WR;
          default:  w_nxt = S_RD;
        endcase
      end
      S_WR, S_RD: if (!AVM_WAITREQUEST) w_nxt = S_DONE;
      S_CLR:      if (!AVM_WAITREQUEST && r_cnt == LP_LAST) w_nxt = S_DONE;
      S_DONE:     w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  // Bus registers only move on accept or on a completed (non-stalled) beat,
  // which keeps them stable for the whole of any wait-request stall.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
        r_cnt   <= '0;
        case (CMD_OP)
          OP_PUT: begin
            r_addr  <= {1'b0, w_idx[11:1]};
            r_be    <= w_idx[0] ? 4'b1100 : 4'b0011;
            r_wdata <= w_idx[0] ? {w_entry, 16'h0} : {16'h0, w_entry};
            r_err   <= w_oor;
          end
          OP_CLEAR: begin
            r_addr  <= '0;
            r_be    <= 4'b1111;
            r_wdata <= {w_entry, w_entry};
          end
          OP_PWR: begin
            r_addr  <= w_pal_addr;
            r_be    <= 4'b1111;
            r_wdata <= CMD_DATA;
          end
          default: begin
            r_addr  <= w_pal_addr;
            r_be    <= 4'b1111;
          end
        endcase
      end
      if (r_state == S_CLR && !AVM_WAITREQUEST) begin
        r_cnt  <= r_cnt + 11'd1;
        r_addr <= {1'b0, r_cnt + 11'd1};
      end
      if (r_state == S_RD && !AVM_WAITREQUEST) r_rdata <= AVM_READDATA;
    end
  end
endmodule

// File: tb/tb_vga_text_avl_writer.sv
// Randomized bench for vga_text_avl_writer: a command-level reference model
// predicts every bus transfer, response and latency; a slave model serves reads.
module tb_vga_text_avl_writer;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [6:0]  CMD_X;
  logic [4:0]  CMD_Y;
  logic [7:0]  CMD_CHAR;
  logic [7:0]  CMD_ATTR;
  logic [31:0] CMD_DATA;
  logic        RSP_VALID;
  logic        RSP_ERR;
  logic [31:0] RSP_DATA;
  logic [11:0] AVM_ADDR;
  logic        AVM_CS;
  logic        AVM_READ;
  logic        AVM_WRITE;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic [31:0] AVM_READDATA;
  logic        AVM_WAITREQUEST;

  always #10 CLK = ~CLK;

  vga_text_avl_writer dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_X(CMD_X), .CMD_Y(CMD_Y), .CMD_CHAR(CMD_CHAR), .CMD_ATTR(CMD_ATTR),
    .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR),
    .RSP_DATA(RSP_DATA), .AVM_ADDR(AVM_ADDR), .AVM_CS(AVM_CS),
    .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE), .AVM_BYTE_EN(AVM_BYTE_EN),
    .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_READDATA(AVM_READDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST)
  );

  typedef struct {
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic        rd;
  } xfer_t;

  logic [31:0] mem [0:4095];
  logic [31:0] pal_model [0:7];
  xfer_t       exp_q[$];
  int          n_vec = 0, n_err = 0;
  int          stall_cnt = 0;
  bit          mon_en = 0, mem_init = 0, rand_stall = 0, trig = 0;
  int          stall_at = -1, fcnt = 0;
  logic        p_stall = 1'b0;
  logic [11:0] p_addr;
  logic [3:0]  p_be;
  logic [31:0] p_wdata;
  logic [1:0]  p_rw;

  assign AVM_READDATA = mem[AVM_ADDR];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Wait-request source: random stalls, or a forced 3-cycle stall at one address.
  initial begin
    AVM_WAITREQUEST = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (fcnt > 0) begin
        AVM_WAITREQUEST = 1'b1;
        fcnt--;
      end else if (!trig && AVM_WRITE && int'(AVM_ADDR) == stall_at) begin
        AVM_WAITREQUEST = 1'b1;
        fcnt = 2;
        trig = 1;
      end else begin
        AVM_WAITREQUEST = rand_stall && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Bus monitor and slave memory.
  always @(negedge CLK) begin
    xfer_t e;
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem_init = 1;
    end
    if (mon_en) begin
      chk("cs_eq", 32'(AVM_CS), 32'(AVM_READ | AVM_WRITE));
      chk("rw_excl", 32'(AVM_READ & AVM_WRITE), 32'd0);
      chk("err_qual", 32'(RSP_ERR & ~RSP_VALID), 32'd0);
      if (p_stall) begin
        chk("hold_addr", 32'(AVM_ADDR), 32'(p_addr));
        chk("hold_be", 32'(AVM_BYTE_EN), 32'(p_be));
        chk("hold_wdata", AVM_WRITEDATA, p_wdata);
        chk("hold_rw", 32'({AVM_READ, AVM_WRITE}), 32'(p_rw));
      end
      if (AVM_CS) begin
        if (AVM_WAITREQUEST) stall_cnt++;
        else begin
          if (exp_q.size() == 0) chk("xfer_extra", 32'(AVM_ADDR), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("xfer_addr", 32'(AVM_ADDR), 32'(e.a));
            chk("xfer_be", 32'(AVM_BYTE_EN), 32'(e.be));
            chk("xfer_rd", 32'(AVM_READ), 32'(e.rd));
            if (!e.rd) chk("xfer_wdata", AVM_WRITEDATA, e.d);
          end
          if (AVM_WRITE)
            for (int b = 0; b < 4; b++)
              if (AVM_BYTE_EN[b]) mem[AVM_ADDR][8*b +: 8] = AVM_WRITEDATA[8*b +: 8];
        end
      end
      p_stall = AVM_CS && AVM_WAITREQUEST;
      p_addr  = AVM_ADDR;
      p_be    = AVM_BYTE_EN;
      p_wdata = AVM_WRITEDATA;
      p_rw    = {AVM_READ, AVM_WRITE};
    end
  end

  task automatic push(input int a, input logic [3:0] be, input logic [31:0] d, input logic rd);
    xfer_t x;
    x.a = 12'(a); x.be = be; x.d = d; x.rd = rd;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] x, input logic [4:0] y,
                       input logic [7:0] ch, input logic [7:0] at, input logic [31:0] d);
    int t;
    CMD_OP = op; CMD_X = x; CMD_Y = y; CMD_CHAR = ch; CMD_ATTR = at; CMD_DATA = d;
    CMD_VALID = 1'b1;
    t = 0;
    while (!CMD_READY && t < 100) begin @(posedge CLK); #1; t++; end
    if (!CMD_READY) chk("ready_timeout", 32'(CMD_READY), 32'd1);
    @(posedge CLK); #1;
    stall_cnt = 0;
    CMD_VALID = 1'b0;
    // Scramble the fields: the block must work from its latched copy.
    CMD_OP = 2'($urandom); CMD_X = 7'($urandom); CMD_Y = 5'($urandom);
    CMD_CHAR = 8'($urandom); CMD_ATTR = 8'($urandom); CMD_DATA = $urandom;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [6:0] x, input logic [4:0] y,
                        input logic [7:0] ch, input logic [7:0] at, input logic [31:0] d,
                        output int lat);
    int nx, idx;
    bit oor;
    logic [31:0] exp_rd;
    logic [15:0] ent;
    ent = {ch, at}; nx = 0; oor = 0; exp_rd = 32'h0;
    case (op)
      2'd0: begin
        oor = (int'(x) >= 80) || (int'(y) >= 30);
        if (!oor) begin
          idx = int'(y) * 80 + int'(x);
          if (idx % 2 == 1) push(idx / 2, 4'hC, {ent, 16'h0}, 1'b0);
          else              push(idx / 2, 4'h3, {16'h0, ent}, 1'b0);
          nx = 1;
        end
      end
      2'd1: begin
        for (int w = 0; w < 1200; w++) push(w, 4'hF, {ent, ent}, 1'b0);
        nx = 1200;
      end
      2'd2: begin
        push(32'h800 + int'(d % 8), 4'hF, d, 1'b0);
        pal_model[d % 8] = d;
        nx = 1;
      end
      default: begin
        push(32'h800 + int'(d % 8), 4'hF, 32'h0, 1'b1);
        exp_rd = pal_model[d % 8];
        nx = 1;
      end
    endcase
    issue(op, x, y, ch, at, d);
    lat = 1;
    while (!RSP_VALID && lat < 5000) begin @(posedge CLK); #1; lat++; end
    chk("rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("rsp_latency", 32'(lat), oor ? 32'd1 : 32'(nx + stall_cnt + 1));
    chk("rsp_err", 32'(RSP_ERR), 32'(oor));
    chk("rsp_data", RSP_DATA, exp_rd);
    @(posedge CLK); #1;
    chk("rsp_pulse", 32'(RSP_VALID), 32'd0);
    chk("ready_after", 32'(CMD_READY), 32'd1);
    chk("xfer_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int lat, t, r;
    logic [6:0] x;
    logic [4:0] y;
    for (int i = 0; i < 8; i++) pal_model[i] = 32'h0;
    RESET = 1'b0; CMD_VALID = 1'b1; CMD_OP = 2'd1; CMD_X = '0; CMD_Y = '0;
    CMD_CHAR = 8'h20; CMD_ATTR = 8'h07; CMD_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_strobes", 32'({AVM_CS, AVM_READ, AVM_WRITE}), 32'd0);
    chk("rst_rsp", 32'({RSP_VALID, RSP_ERR}), 32'd0);
    RESET = 1'b1; CMD_VALID = 1'b0;
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_addr", 32'(AVM_ADDR), 32'd0);
    chk("rst_be", 32'(AVM_BYTE_EN), 32'd0);
    chk("rst_wdata", AVM_WRITEDATA, 32'd0);
    chk("rst_rdata", RSP_DATA, 32'd0);
    mon_en = 1;

    // Directed: mid-row odd index, both out-of-range edges, palette round trip.
    do_cmd(2'd0, 7'd3, 5'd2, 8'h41, 8'h1F, 32'h0, lat);
    chk("put_lat", 32'(lat), 32'd2);
    do_cmd(2'd0, 7'd80, 5'd0, 8'h41, 8'h1F, 32'h0, lat);
    do_cmd(2'd0, 7'd0, 5'd30, 8'h41, 8'h1F, 32'h0, lat);
    do_cmd(2'd0, 7'd79, 5'd29, 8'h7E, 8'hA5, 32'h0, lat);
    do_cmd(2'd2, 7'd0, 5'd0, 8'h0, 8'h0, 32'h0F00_00F0 | 32'd5, lat);
    do_cmd(2'd3, 7'd0, 5'd0, 8'h0, 8'h0, 32'd5, lat);
    chk("pal_rd_word", RSP_DATA, 32'h0F00_00F5);
    chk("pal_rd_lat", 32'(lat), 32'd2);

    // Full clear with a forced 3-cycle stall at word 600.
    stall_at = 600; trig = 0;
    do_cmd(2'd1, 7'd0, 5'd0, 8'h20, 8'h07, 32'h0, lat);
    chk("clr_lat", 32'(lat), 32'd1204);
    stall_at = -1;

    // Reset in the middle of a clear: no response, strobes drop at the edge.
    for (int w = 0; w < 1200; w++) push(w, 4'hF, 32'h5A3C_5A3C, 1'b0);
    issue(2'd1, 7'd0, 5'd0, 8'h5A, 8'h3C, 32'h0);
    t = 0;
    while (!(AVM_WRITE && AVM_ADDR == 12'd400) && t < 2000) begin @(posedge CLK); #1; t++; end
    chk("clr_reach_400", 32'(AVM_ADDR), 32'd400);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("abort_strobes", 32'({AVM_CS, AVM_READ, AVM_WRITE}), 32'd0);
    chk("abort_rsp", 32'(RSP_VALID), 32'd0);
    RESET = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(posedge CLK); #1;
      chk("abort_no_rsp", 32'(RSP_VALID), 32'd0);
    end
    do_cmd(2'd0, 7'd10, 5'd5, 8'h42, 8'h2E, 32'h0, lat);

    // Random commands with random wait-request stalls.
    rand_stall = 1;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      x = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79));
      y = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(30, 31)) : 5'($urandom_range(0, 29));
      do_cmd(r < 5 ? 2'd0 : (r < 7 ? 2'd2 : 2'd3), x, y, 8'($urandom), 8'($urandom),
             $urandom, lat);
    end
    do_cmd(2'd1, 7'd0, 5'd0, 8'($urandom), 8'($urandom), 32'h0, lat);
    rand_stall = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
